// File: rtl/program_counter.sv
// MC14500B instruction-address generator with a small hardware return stack.
// One-cycle latency: pc/sp update on the edge that samples step and the ICU controls.
module program_counter #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4,
    localparam int SP_W       = $clog2(STACK_DEPTH + 1),
    localparam int IDX_W      = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              step,
    input  logic              jmp,
    input  logic              call,
    input  logic              rtn,
    input  logic              skip,
    input  logic [ADDR_W-1:0] jmp_addr,
    output logic [ADDR_W-1:0] pc,
    output logic [SP_W-1:0]   sp,
    output logic              stack_full,
    output logic              overflow,
    output logic              underflow
);

    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_JMP,
        ACT_CALL,
        ACT_CALL_OVF,
        ACT_RET,
        ACT_RET_UNF,
        ACT_SKIP,
        ACT_INC
    } action_e;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

    action_e           act;
    logic              full;
    logic              empty;
    logic              push_en;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_inc2;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;

    assign full    = (sp_q == SP_W'(STACK_DEPTH));
    assign empty   = (sp_q == '0);
    assign pc_inc  = pc_q + ADDR_W'(1);
    assign pc_inc2 = pc_q + ADDR_W'(2);
    assign wr_idx  = IDX_W'(sp_q);
    // rd_idx wraps when empty, but a pop is never decoded in that case.
    assign rd_idx  = IDX_W'(sp_q - SP_W'(1));

    // Priority decode: jmp > rtn > skip > increment; call only qualifies jmp.
    always_comb begin
        act = ACT_HOLD;
        if (step) begin
            if (jmp) begin
                if (call) act = full ? ACT_CALL_OVF : ACT_CALL;
                else      act = ACT_JMP;
            end else if (rtn) begin
                act = empty ? ACT_RET_UNF : ACT_RET;
            end else if (skip) begin
                act = ACT_SKIP;
            end else begin
                act = ACT_INC;
            end
        end
    end

    always_comb begin
        pc_d    = pc_q;
        sp_d    = sp_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push_en = 1'b0;
        unique case (act)
            ACT_HOLD: ;
            ACT_JMP:  pc_d = jmp_addr;
            ACT_CALL: begin
                pc_d    = jmp_addr;
                sp_d    = sp_q + SP_W'(1);
                push_en = 1'b1;
            end
            ACT_CALL_OVF: begin
                pc_d  = jmp_addr;
                ovf_d = 1'b1;
            end
            ACT_RET: begin
                pc_d = stack_q[rd_idx];
                sp_d = sp_q - SP_W'(1);
            end
            ACT_RET_UNF: begin
                pc_d  = pc_inc;
                unf_d = 1'b1;
            end
            ACT_SKIP: pc_d = pc_inc2;
            ACT_INC:  pc_d = pc_inc;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= '0;
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Stack storage needs no reset: entries at or above sp are never read.
    always_ff @(posedge clk) begin
        if (push_en && !reset) begin
            stack_q[wr_idx] <= pc_inc;
        end
    end

    assign pc         = pc_q;
    assign sp         = sp_q;
    assign stack_full = full;
    assign overflow   = ovf_q;
    assign underflow  = unf_q;

endmodule

// File: tb/tb_program_counter.sv
// Directed bench for program_counter (ADDR_W=8, STACK_DEPTH=4).
// Checks compare {pc, sp, stack_full, overflow, underflow} against hand-computed values.
module tb_program_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       step;
    logic       jmp;
    logic       call;
    logic       rtn;
    logic       skip;
    logic [7:0] jmp_addr;
    logic [7:0] pc;
    logic [2:0] sp;
    logic       stack_full;
    logic       overflow;
    logic       underflow;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    program_counter #(.ADDR_W(8), .STACK_DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .step       (step),
        .jmp        (jmp),
        .call       (call),
        .rtn        (rtn),
        .skip       (skip),
        .jmp_addr   (jmp_addr),
        .pc         (pc),
        .sp         (sp),
        .stack_full (stack_full),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    // Drive one cycle of controls, clock it, and settle 1ns past the edge.
    task automatic cyc(input logic s, input logic j, input logic c,
                       input logic r, input logic k, input logic [7:0] a);
        step = s; jmp = j; call = c; rtn = r; skip = k; jmp_addr = a;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 8'h00);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        apply_reset(2);
        n_checks++;
        if ({pc, sp, stack_full, overflow, underflow} !== {8'h00, 3'd0, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_state: pc=%h sp=%0d full=%b ovf=%b unf=%b expected pc=00 sp=0 flags 000",
                     pc, sp, stack_full, overflow, underflow);
        end
    endtask

    task automatic test_sequential;
        logic [7:0] exp_pc [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 0, 0, 0, 8'h00);
            n_checks++;
            if ({pc, sp, stack_full, overflow, underflow} !== {exp_pc[i], 3'd0, 3'b000}) begin
                n_fail++;
                $display("FAIL seq_fetch[%0d]: pc=%h sp=%0d flags=%b%b%b expected pc=%h sp=0 flags 000",
                         i, pc, sp, stack_full, overflow, underflow, exp_pc[i]);
            end
            if (i == 2) begin
                // Stalled cycle: controls present but must be ignored.
                cyc(0, 1, 1, 0, 0, 8'hAA);
                n_checks++;
                if ({pc, sp} !== {8'h03, 3'd0}) begin
                    n_fail++;
                    $display("FAIL seq_stall: pc=%h sp=%0d expected pc=03 sp=0", pc, sp);
                end
            end
        end
    endtask

    task automatic test_call_return;
        cyc(1, 1, 0, 0, 0, 8'h10);
        cyc(1, 1, 1, 0, 0, 8'h40);
        n_checks++;
        if ({pc, sp, stack_full} !== {8'h40, 3'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL call: pc=%h sp=%0d full=%b expected pc=40 sp=1 full=0", pc, sp, stack_full);
        end
        cyc(1, 0, 0, 0, 0, 8'h00);
        cyc(1, 0, 0, 0, 0, 8'h00);
        n_checks++;
        if ({pc, sp} !== {8'h42, 3'd1}) begin
            n_fail++;
            $display("FAIL call_body: pc=%h sp=%0d expected pc=42 sp=1", pc, sp);
        end
        cyc(1, 0, 0, 1, 0, 8'h00);
        n_checks++;
        if ({pc, sp, overflow, underflow} !== {8'h11, 3'd0, 2'b00}) begin
            n_fail++;
            $display("FAIL return: pc=%h sp=%0d ovf=%b unf=%b expected pc=11 sp=0 ovf=0 unf=0",
                     pc, sp, overflow, underflow);
        end
    endtask

    task automatic test_overflow;
        logic [7:0] tgt [5]  = '{8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
        logic [2:0] esp [5]  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        logic [7:0] ret [4]  = '{8'h41, 8'h31, 8'h21, 8'h09};
        apply_reset(1);
        cyc(1, 1, 0, 0, 0, 8'h08);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 1, 1, 0, 0, tgt[i]);
            n_checks++;
            if ({pc, sp, stack_full, overflow} !== {tgt[i], esp[i], (i >= 3), (i == 4)}) begin
                n_fail++;
                $display("FAIL nest_call[%0d]: pc=%h sp=%0d full=%b ovf=%b expected pc=%h sp=%0d full=%b ovf=%b",
                         i, pc, sp, stack_full, overflow, tgt[i], esp[i], (i >= 3), (i == 4));
            end
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 0, 1, 0, 8'h00);
            n_checks++;
            if ({pc, sp, stack_full, overflow, underflow} !== {ret[i], 3'(3 - i), 3'b010}) begin
                n_fail++;
                $display("FAIL nest_ret[%0d]: pc=%h sp=%0d full=%b ovf=%b unf=%b expected pc=%h sp=%0d flags 010",
                         i, pc, sp, stack_full, overflow, underflow, ret[i], 3 - i);
            end
        end
    endtask

    task automatic test_underflow_priority;
        apply_reset(1);
        cyc(1, 1, 0, 0, 0, 8'h07);
        cyc(1, 0, 0, 1, 0, 8'h00);
        n_checks++;
        if ({pc, sp, overflow, underflow} !== {8'h08, 3'd0, 2'b01}) begin
            n_fail++;
            $display("FAIL underflow: pc=%h sp=%0d ovf=%b unf=%b expected pc=08 sp=0 ovf=0 unf=1",
                     pc, sp, overflow, underflow);
        end
        cyc(1, 1, 1, 0, 0, 8'h20);
        cyc(1, 1, 0, 1, 0, 8'h33);
        n_checks++;
        if ({pc, sp} !== {8'h33, 3'd1}) begin
            n_fail++;
            $display("FAIL jmp_over_rtn: pc=%h sp=%0d expected pc=33 sp=1", pc, sp);
        end
        cyc(1, 0, 1, 0, 0, 8'h77);
        n_checks++;
        if ({pc, sp} !== {8'h34, 3'd1}) begin
            n_fail++;
            $display("FAIL call_no_jmp: pc=%h sp=%0d expected pc=34 sp=1", pc, sp);
        end
        cyc(1, 0, 0, 1, 1, 8'h00);
        n_checks++;
        if ({pc, sp, underflow} !== {8'h09, 3'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL rtn_over_skip: pc=%h sp=%0d unf=%b expected pc=09 sp=0 unf=1", pc, sp, underflow);
        end
    endtask

    task automatic test_wrap;
        apply_reset(1);
        cyc(1, 1, 0, 0, 0, 8'hFE);
        cyc(1, 0, 0, 0, 1, 8'h00);
        n_checks++;
        if (pc !== 8'h00) begin
            n_fail++;
            $display("FAIL skip_wrap_fe: pc=%h expected 00", pc);
        end
        cyc(1, 1, 0, 0, 0, 8'hFF);
        cyc(1, 0, 0, 0, 1, 8'h00);
        n_checks++;
        if (pc !== 8'h01) begin
            n_fail++;
            $display("FAIL skip_wrap_ff: pc=%h expected 01", pc);
        end
        cyc(1, 1, 0, 0, 0, 8'hFF);
        cyc(1, 0, 0, 0, 0, 8'h00);
        n_checks++;
        if (pc !== 8'h00) begin
            n_fail++;
            $display("FAIL inc_wrap: pc=%h expected 00", pc);
        end
        cyc(1, 1, 0, 0, 0, 8'hFF);
        cyc(1, 1, 1, 0, 0, 8'h05);
        n_checks++;
        if ({pc, sp} !== {8'h05, 3'd1}) begin
            n_fail++;
            $display("FAIL call_at_top: pc=%h sp=%0d expected pc=05 sp=1", pc, sp);
        end
        cyc(1, 0, 0, 1, 0, 8'h00);
        n_checks++;
        if ({pc, sp} !== {8'h00, 3'd0}) begin
            n_fail++;
            $display("FAIL ret_wrapped: pc=%h sp=%0d expected pc=00 sp=0", pc, sp);
        end
    endtask

    task automatic test_reset_mid;
        apply_reset(1);
        cyc(1, 1, 1, 0, 0, 8'h20);
        cyc(1, 1, 1, 0, 0, 8'h30);
        cyc(1, 1, 1, 0, 0, 8'h40);
        cyc(1, 1, 1, 0, 0, 8'h50);
        cyc(1, 1, 1, 0, 0, 8'h60);
        cyc(1, 0, 0, 1, 0, 8'h00);
        cyc(1, 1, 0, 0, 0, 8'h44);
        n_checks++;
        if ({pc, sp, overflow} !== {8'h44, 3'd3, 1'b1}) begin
            n_fail++;
            $display("FAIL mid_setup: pc=%h sp=%0d ovf=%b expected pc=44 sp=3 ovf=1", pc, sp, overflow);
        end
        reset = 1'b1;
        cyc(1, 1, 1, 0, 0, 8'h99);
        reset = 1'b0;
        n_checks++;
        if ({pc, sp, stack_full, overflow, underflow} !== {8'h00, 3'd0, 3'b000}) begin
            n_fail++;
            $display("FAIL mid_reset: pc=%h sp=%0d flags=%b%b%b expected pc=00 sp=0 flags 000",
                     pc, sp, stack_full, overflow, underflow);
        end
        cyc(1, 0, 0, 0, 0, 8'h00);
        n_checks++;
        if ({pc, sp} !== {8'h01, 3'd0}) begin
            n_fail++;
            $display("FAIL post_reset_step: pc=%h sp=%0d expected pc=01 sp=0", pc, sp);
        end
    endtask

    initial begin
        reset = 1'b1; step = 1'b0; jmp = 1'b0; call = 1'b0;
        rtn = 1'b0; skip = 1'b0; jmp_addr = 8'h00;
        test_reset;
        test_sequential;
        test_call_return;
        test_overflow;
        test_underflow_priority;
        test_wrap;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
